// File: rtl/led_pulse_stretcher_pkg.sv
// Shared state encodings, default timing constants and the us-to-cycles helper
// for the LED pulse stretcher.
package led_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned DEF_CLK_FREQ_MHZ = 100;
  localparam int unsigned DEF_ON_TIME_US   = 50000;
  localparam int unsigned DEF_GAP_TIME_US  = 50000;
  localparam int unsigned TIMER_W          = 32;

  function automatic logic [TIMER_W-1:0] us_to_cycles(input int unsigned us,
                                                      input int unsigned mhz);
    return TIMER_W'(us * mhz);
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Event/status bundle between a status-strobe source and one LED stretcher.
interface led_pulse_stretcher_if #(
  parameter int PEND_WIDTH = 4
);
  logic                  evt_i;
  logic                  clr_ovf_i;
  logic                  led_o;
  logic                  busy_o;
  logic [PEND_WIDTH-1:0] pend_o;
  logic                  ovf_o;

  modport master (output evt_i, clr_ovf_i, input led_o, busy_o, pend_o, ovf_o);
  modport slave  (input evt_i, clr_ovf_i, output led_o, busy_o, pend_o, ovf_o);
endinterface

// File: rtl/led_pulse_stretcher_cycle_timer.sv
// 32-bit down counter: load N-1 on state entry, done while the count is zero.
module cycle_timer
  import led_pulse_stretcher_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle event strobes into LED blinks with minimum ON and gap
// times, queuing events that arrive faster than they can be shown.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ,
  parameter int unsigned ON_TIME_US   = DEF_ON_TIME_US,
  parameter int unsigned GAP_TIME_US  = DEF_GAP_TIME_US,
  parameter int          PEND_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  led_pulse_stretcher_if.slave   bus
);

  localparam logic [TIMER_W-1:0] ON_CYC  = us_to_cycles(ON_TIME_US, CLK_FREQ_MHZ);
  localparam logic [TIMER_W-1:0] GAP_CYC = us_to_cycles(GAP_TIME_US, CLK_FREQ_MHZ);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  state_e                state_q, state_d;
  logic                  load;
  logic [TIMER_W-1:0]    load_val;
  logic                  done;
  logic                  inc, dec;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d, ovf_set;
  logic                  led_q, busy_q;

  cycle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    inc      = 1'b0;
    dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.evt_i) begin
          state_d  = ST_ON;
          load     = 1'b1;
          load_val = ON_CYC - TIMER_W'(1);
        end
      end
      ST_ON: begin
        inc = bus.evt_i;
        if (done) begin
          state_d  = ST_GAP;
          load     = 1'b1;
          load_val = GAP_CYC - TIMER_W'(1);
        end
      end
      ST_GAP: begin
        if (!done) begin
          inc = bus.evt_i;
        end else if (pend_q != '0 || bus.evt_i) begin
          // Oldest queued event goes first; a fresh strobe then joins the queue.
          dec      = (pend_q != '0);
          inc      = (pend_q != '0) && bus.evt_i;
          state_d  = ST_ON;
          load     = 1'b1;
          load_val = ON_CYC - TIMER_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (inc && !dec) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else                    pend_d  = pend_q + PEND_WIDTH'(1);
    end else if (dec && !inc) begin
      pend_d = pend_q - PEND_WIDTH'(1);
    end
    // A new overflow wins over a coincident clear.
    ovf_d = ovf_set ? 1'b1 : (bus.clr_ovf_i ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= (state_d == ST_ON);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.led_o  = led_q;
  assign bus.busy_o = busy_q;
  assign bus.pend_o = pend_q;
  assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench: ON_CYC=4, GAP_CYC=3, PEND_WIDTH=2; per-cycle expectations
// are written as strings, one character per cycle.
module tb_led_pulse_stretcher;

  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_pulse_stretcher_if #(.PEND_WIDTH(PW)) bus ();

  led_pulse_stretcher #(
    .CLK_FREQ_MHZ (1),
    .ON_TIME_US   (4),
    .GAP_TIME_US  (3),
    .PEND_WIDTH   (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Observed {led, busy, pend, ovf} per cycle of the last played vector.
  logic [PW+2:0] obs [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records outputs at cycle i, then drives the strobes for cycle i.
  task automatic play(input string evt_s, input string clr_s);
    for (int i = 0; i < evt_s.len(); i++) begin
      obs[i] = {bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o};
      bus.evt_i     = (evt_s[i] == "1");
      bus.clr_ovf_i = (clr_s[i] == "1");
      tick();
    end
    bus.evt_i     = 1'b0;
    bus.clr_ovf_i = 1'b0;
  endtask

  function automatic logic [PW+2:0] exp_at(input string led_s, input string busy_s,
                                           input string pend_s, input string ovf_s,
                                           input int i);
    int v;
    logic [PW-1:0] p;
    v = int'(pend_s[i]) - 48;
    p = v[PW-1:0];
    return {led_s[i] == "1", busy_s[i] == "1", p, ovf_s[i] == "1"};
  endfunction

  // Idle must never coexist with queued events.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (bus.busy_o === 1'b0 && bus.pend_o !== '0) begin
        errors++;
        $display("FAIL idle_invariant t=%0t pend_o got %0d expected 0 while idle", $time, bus.pend_o);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.evt_i = 1'b0;
    bus.clr_ovf_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o} !== '0) begin
      errors++;
      $display("FAIL reset_state led/busy/pend/ovf got %b expected 0",
               {bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o});
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got %b expected 0", i,
                 {bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o});
      end
    end
  endtask

  task automatic test_single();
    string evt_s  = "100000000";
    string clr_s  = "000000000";
    string led_s  = "011110000";
    string busy_s = "011111110";
    string pend_s = "000000000";
    string ovf_s  = "000000000";
    play(evt_s, clr_s);
    for (int i = 0; i < evt_s.len(); i++) begin
      checks++;
      if (obs[i] !== exp_at(led_s, busy_s, pend_s, ovf_s, i)) begin
        errors++;
        $display("FAIL single cycle %0d led/busy/pend/ovf got %b expected %b",
                 i, obs[i], exp_at(led_s, busy_s, pend_s, ovf_s, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    string evt_s  = "11100000000000000000000";
    string clr_s  = "00000000000000000000000";
    string led_s  = "01111000111100011110000";
    string busy_s = "01111111111111111111110";
    string pend_s = "00122222111111100000000";
    string ovf_s  = "00000000000000000000000";
    play(evt_s, clr_s);
    for (int i = 0; i < evt_s.len(); i++) begin
      checks++;
      if (obs[i] !== exp_at(led_s, busy_s, pend_s, ovf_s, i)) begin
        errors++;
        $display("FAIL back_to_back cycle %0d led/busy/pend/ovf got %b expected %b",
                 i, obs[i], exp_at(led_s, busy_s, pend_s, ovf_s, i));
      end
    end
  endtask

  task automatic test_gap_coincident();
    string evt_s  = "11000001000000000000000";
    string clr_s  = "00000000000000000000000";
    string led_s  = "01111000111100011110000";
    string busy_s = "01111111111111111111110";
    string pend_s = "00111111111111100000000";
    string ovf_s  = "00000000000000000000000";
    play(evt_s, clr_s);
    for (int i = 0; i < evt_s.len(); i++) begin
      checks++;
      if (obs[i] !== exp_at(led_s, busy_s, pend_s, ovf_s, i)) begin
        errors++;
        $display("FAIL gap_coincident cycle %0d led/busy/pend/ovf got %b expected %b",
                 i, obs[i], exp_at(led_s, busy_s, pend_s, ovf_s, i));
      end
    end
  endtask

  // Saturate, clear, inc+dec at max (no overflow), then clear racing a drop.
  task automatic test_saturation();
    string evt_s  = "111110011000";
    string clr_s  = "000000101000";
    string led_s  = "011110001111";
    string busy_s = "011111111111";
    string pend_s = "001233333333";
    string ovf_s  = "000001100111";
    play(evt_s, clr_s);
    for (int i = 0; i < evt_s.len(); i++) begin
      checks++;
      if (obs[i] !== exp_at(led_s, busy_s, pend_s, ovf_s, i)) begin
        errors++;
        $display("FAIL saturation cycle %0d led/busy/pend/ovf got %b expected %b",
                 i, obs[i], exp_at(led_s, busy_s, pend_s, ovf_s, i));
      end
    end
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick();
    play("111", "000");
    checks++;
    if ({bus.led_o, bus.pend_o} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL async_reset_setup led/pend got %b expected %b", {bus.led_o, bus.pend_o}, {1'b1, 2'd2});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o} !== '0) begin
      errors++;
      $display("FAIL async_reset_drop led/busy/pend/ovf got %b expected 0",
               {bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o});
    end
    tick();
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if ({bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o} !== '0) begin
        errors++;
        $display("FAIL async_reset_quiet cycle %0d got %b expected 0", i,
                 {bus.led_o, bus.busy_o, bus.pend_o, bus.ovf_o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap_coincident();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
